// File: rtl/pwm_regs_pkg.sv
// Shared register-map constants for the PWM register bank.
// Used by block_duty_ramp and duty_ramp_channel.
package pwm_regs_pkg;

    localparam logic [7:0] ADDR_OE      = 8'h00;
    localparam logic [7:0] ADDR_CH_BASE = 8'h01;
    localparam logic [7:0] ADDR_ALL_OFF = 8'hFF;

    localparam int DW_DEFAULT = 8;

endpackage

// File: rtl/duty_ramp_channel.sv
// One PWM channel: target register plus live duty that slews toward it.
// Slew logic is present only when DUTY_RAMP_EN is defined.
module duty_ramp_channel
    import pwm_regs_pkg::*;
#(
    parameter int DW   = DW_DEFAULT,
    parameter int STEP = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick,
    input  logic          load_en,
    input  logic [DW-1:0] load_val,
    input  logic          clear,
    output logic [DW-1:0] cur,
    output logic          at_target
);

    logic [DW-1:0] tgt_q, tgt_d;
    logic [DW-1:0] cur_q, cur_d;

`ifdef DUTY_RAMP_EN
    localparam logic [DW:0] STEP_W = (DW+1)'(STEP);

    logic [DW:0] up_s;
    logic [DW:0] dn_s;

    // Next target and clamped one-step slew of the live duty
    always_comb begin
        tgt_d = tgt_q;
        cur_d = cur_q;
        up_s  = {1'b0, cur_q} + STEP_W;
        dn_s  = {1'b0, cur_q} - STEP_W;
        if (tick) begin
            if (cur_q < tgt_q) begin
                cur_d = (up_s > {1'b0, tgt_q}) ? tgt_q : up_s[DW-1:0];
            end else if (cur_q > tgt_q) begin
                cur_d = (dn_s[DW] || (dn_s < {1'b0, tgt_q}))
                      ? tgt_q : dn_s[DW-1:0];
            end
        end
        if (load_en) begin
            tgt_d = load_val;
        end
        if (clear) begin
            tgt_d = '0;
            cur_d = '0;
        end
    end
`else
    logic [31:0] unused_cfg;
    assign unused_cfg = 32'(STEP) ^ {31'd0, tick};

    // Next target; live duty copies the target one cycle later
    always_comb begin
        tgt_d = tgt_q;
        cur_d = tgt_q;
        if (load_en) begin
            tgt_d = load_val;
        end
        if (clear) begin
            tgt_d = '0;
            cur_d = '0;
        end
    end
`endif

    // Channel state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_q <= '0;
            cur_q <= '0;
        end else begin
            tgt_q <= tgt_d;
            cur_q <= cur_d;
        end
    end

    assign cur       = cur_q;
    assign at_target = (cur_q == tgt_q);

endmodule

// File: rtl/block_duty_ramp.sv
// Register bank: decodes SPI writes into channel duties and D8 enable.
// Define DUTY_RAMP_EN to enable the prescaled duty slew.
module block_duty_ramp
    import pwm_regs_pkg::*;
#(
    parameter int NUM_CH   = 7,
    parameter int DW       = DW_DEFAULT,
    parameter int RAMP_DIV = 1000,
    parameter int STEP     = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 data_ready,
    input  logic [7:0]           address,
    input  logic [DW-1:0]        data,
    output logic [NUM_CH*DW-1:0] duty_out,
    output logic                 d8_oe,
    output logic                 busy
);

    logic [NUM_CH-1:0] wr_ch;
    logic [NUM_CH-1:0] at_tgt;
    logic [DW-1:0]     cur [NUM_CH];
    logic              wr_oe;
    logic              wr_off;
    logic              tick;
    logic              d8_oe_q, d8_oe_d;

    // Address decode and next output-enable value
    always_comb begin
        wr_oe  = data_ready && (address == ADDR_OE);
        wr_off = data_ready && (address == ADDR_ALL_OFF);
        for (int i = 0; i < NUM_CH; i++) begin
            wr_ch[i] = data_ready && (address == ADDR_CH_BASE + 8'(i));
        end
        d8_oe_d = wr_oe ? ~data[0] : d8_oe_q;
    end

    // Output-enable register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d8_oe_q <= 1'b0;
        end else begin
            d8_oe_q <= d8_oe_d;
        end
    end

    assign d8_oe = d8_oe_q;

    genvar g;
    for (g = 0; g < NUM_CH; g++) begin : g_ch
        duty_ramp_channel #(
            .DW   (DW),
            .STEP (STEP)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .tick      (tick),
            .load_en   (wr_ch[g]),
            .load_val  (data),
            .clear     (wr_off),
            .cur       (cur[g]),
            .at_target (at_tgt[g])
        );
        assign duty_out[g*DW +: DW] = cur[g];
    end

`ifdef DUTY_RAMP_EN
    localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    logic [PW-1:0] psc_q, psc_d;

    // Free-running prescaler; tick on the last count
    always_comb begin
        tick  = (psc_q == PW'(RAMP_DIV - 1));
        psc_d = tick ? '0 : psc_q + PW'(1);
    end

    // Prescaler register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_q <= '0;
        end else begin
            psc_q <= psc_d;
        end
    end

    assign busy = ~&at_tgt;
`else
    logic [31:0] unused_div;
    assign unused_div = 32'(RAMP_DIV) ^ {{(32-1){1'b0}}, &at_tgt};

    assign tick = 1'b0;
    assign busy = 1'b0;
`endif

endmodule
